// File: rtl/spike_decoder_pkg.sv
// Shared types and constants for the spike-train decoder: FSM states,
// default window/width and the count-to-magnitude scale shift.
package rpu_spike_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int WINDOW_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // count * (2^DATA_W / WINDOW) is a left shift by log2(2^DATA_W / WINDOW)
  localparam int SCALE_SHIFT = DATA_W_DEF - $clog2(WINDOW_DEF);

  function automatic int scale_shift(input int window, input int data_w);
    return data_w - $clog2(window);
  endfunction

endpackage

// File: rtl/spike_decoder_window_counter.sv
// Cycle counter plus spike accumulator for one decode window; pulses done
// on the last sample edge with the final count (accumulator + current spike).
module spike_window_counter #(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic       spike_in,
  output logic       done,
  output logic [8:0] final_count
);

  localparam int CW = $clog2(WINDOW);

  logic [CW-1:0] cyc_reg;
  logic [8:0]    acc_reg;
  logic          last;

  assign last        = (cyc_reg == CW'(WINDOW - 1));
  assign done        = sample && last;
  assign final_count = acc_reg + 9'(spike_in);

  // Any cycle without sampling discards the partial window, so the
  // accumulator holds at most WINDOW-1 and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_reg <= '0;
      acc_reg <= '0;
    end else if (!sample || last) begin
      cyc_reg <= '0;
      acc_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + 1'b1;
      acc_reg <= acc_reg + 9'(spike_in);
    end
  end

endmodule

// File: rtl/spike_decoder.sv
// Rate decoder: counts spikes over fixed windows while enabled and reports a
// scaled, saturated magnitude through a valid/ready output with overrun flag.
module spike_decoder
  import rpu_spike_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              spike_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [8:0]        out_count,
  output logic              overrun
);

  localparam int SHIFT = scale_shift(WINDOW, DATA_W);
  localparam int SW    = 9 + DATA_W;

  state_t            state_reg, state_next;
  logic              sample;
  logic              done;
  logic [8:0]        final_count;
  logic [SW-1:0]     scaled;
  logic [DATA_W-1:0] sat_max;
  logic [DATA_W-1:0] data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable)  state_next = ACCUM;
      ACCUM:   if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sample = (state_reg == ACCUM) && enable;

  spike_window_counter #(.WINDOW(WINDOW)) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample      (sample),
    .spike_in    (spike_in),
    .done        (done),
    .final_count (final_count)
  );

  assign sat_max   = {DATA_W{1'b1}};
  assign scaled    = SW'(final_count) << SHIFT;
  assign data_next = (scaled > SW'(sat_max)) ? sat_max : scaled[DATA_W-1:0];

  // A completing window always wins over a transfer; it only counts as an
  // overrun when the previous result is still pending and not being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      overrun   <= 1'b0;
    end else if (done) begin
      out_valid <= 1'b1;
      out_data  <= data_next;
      out_count <= final_count;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 SHALL have parameter WINDOW, default 16: sample cycles per decode window; power of two, 2..256.
REQ-002 SHALL have parameter DATA_W, default 8: width of the decoded value.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: high = decode windows run; low = idle.
REQ-006 SHALL have port spike_in, input, 1: spike train from the sensor encoder; one spike per high cycle.
REQ-007 SHALL have port out_ready, input, 1: downstream accepts out_data when high.
REQ-008 SHALL have port out_valid, output, 1: out_data/out_count hold a completed, unconsumed window result.
REQ-009 SHALL have port out_data, output, DATA_W: reconstructed sensor magnitude.
REQ-010 SHALL have port out_count, output, 9: raw spike count of the reported window, 0..WINDOW.
REQ-011 SHALL have port overrun, output, 1: sticky flag; an unconsumed result was overwritten.

Function
REQ-012 SHALL implement FSM states IDLE and ACCUM; IDLE -> ACCUM at the edge that samples enable=1; ACCUM -> IDLE at the edge that samples enable=0.
REQ-013 SHALL hold the cycle counter and spike accumulator at 0 in IDLE.
REQ-014 SHALL sample spike_in only in ACCUM: if enable is first sampled high at edge E0, the window samples edges E1..E_WINDOW.
REQ-015 SHALL, at the window's last sample edge, compute final count = accumulator + spike_in, load the output registers, and zero both counters.
REQ-016 SHALL, after REQ-015, start the next window on the following edge without a gap while enable stays high.
REQ-017 SHALL compute out_data = min(count * (2^DATA_W / WINDOW), 2^DATA_W - 1), so count = WINDOW saturates to 255 at DATA_W = 8.
REQ-018 SHALL set out_count = count, zero-extended.
REQ-019 SHALL assert out_valid after the last-sample edge, giving a latency of WINDOW+1 edges from E0 to valid.
REQ-020 SHALL keep out_data and out_count stable while out_valid=1 and out_ready=0.
REQ-021 SHALL complete a transfer on an edge with out_valid=1 and out_ready=1, clearing out_valid after that edge unless REQ-022 applies.
REQ-022 SHALL, when a window completes on the same edge as a transfer, load the new result and keep out_valid=1 with no overrun.
REQ-023 SHALL, when a window completes while out_valid=1 and out_ready=0, overwrite the result with the newest one, keep out_valid=1, and set overrun=1.
REQ-024 SHALL clear overrun only by reset.
REQ-025 SHALL, when enable drops mid-window, discard the partial count, produce no result, and leave out_valid and pending data untouched.
REQ-026 SHALL restart the next enable from a full, fresh window.
REQ-027 SHALL never let the accumulator exceed WINDOW or wrap.

Reset
REQ-028 SHALL, on rst_n low, immediately force state=IDLE, counters=0, out_valid=0, out_data=0, out_count=0, overrun=0, independent of clk.
REQ-029 SHALL abandon any window in progress when reset asserts mid-operation.
REQ-030 SHALL resume operation at the first clock edge after rst_n is released.

Structure
REQ-031 SHALL place the FSM state enum, the default WINDOW/DATA_W constants, and the scale-shift constant log2(2^DATA_W/WINDOW) in shared package rpu_spike_pkg.
REQ-032 SHALL implement the cycle counter plus spike accumulator as the single sub-module spike_window_counter, which issues a window-done pulse with the final count.
REQ-033 SHALL implement the scaling as a shift plus saturation, with no multiplier.

Verification (WINDOW=16, DATA_W=8)
REQ-034 SHALL test enable held high, spike_in=1 every cycle, out_ready=1 -> out_count=16 and out_data=255 at edge E17, then every 16 edges.
REQ-035 SHALL test spike_in alternating 1/0 -> out_count=8, out_data=128; with spike_in=0 throughout -> out_count=0, out_data=0, out_valid still asserted.
REQ-036 SHALL test out_ready=0 across two windows with counts 4 then 12 -> out_data 64 then 192, out_valid stays 1, overrun=1 after the second window.
REQ-037 SHALL test a transfer coinciding with window completion -> out_valid stays 1, new data visible, overrun=0.
REQ-038 SHALL test enable dropped after 7 sample edges -> no out_valid; re-enable -> a full 16-sample window is reported.
REQ-039 SHALL test rst_n low mid-window with out_valid=1 -> all outputs 0 before the next clk edge; the first result after release comes from a fresh window.
